glitcbus_master: RTL and testbench
==================================

// Module: glitcbus_master
// PURPOSE
// Initiator end of GLITCBUS: turns single 32-bit register read/write requests into the
// byte-serial GSEL_B/GRDWR_B/GAD[7:0] transaction that glitcbus_slave_v2 decodes.
// Sits in TISC-side and loopback test firmware. Drives the GLITC register map over GLITCBUS:
// ctrl 0x00, ps 0x10, datapath 0x20, dac 0x40, i2c 0x50.
// Owns GAD direction control. The pad tristate sits outside this block.
// PARAMETERS
// RD_WAIT   1  turnaround cycles between address byte 1 and the first read-data byte (1..7)
// IDLE_GAP  1  cycles GSEL_B stays high after each transaction before the next is accepted (1..7)
// PORTS
// clk_i       in   1   GLITCBUS clock. All logic is on the rising edge.
// rst_i       in   1   synchronous, active-high reset
// req_i       in   1   one-cycle request strobe. Accepted only when busy_o=0.
// we_i        in   1   1=write, 0=read. Sampled with req_i.
// adr_i       in   16  register address. Sampled with req_i.
// dat_i       in   32  write data. Sampled with req_i.
// busy_o      out  1   transaction in progress, including the gap cycles
// ack_o       out  1   one-cycle pulse when a transaction completes
// dat_o       out  32  read data. Valid with ack_o; held until the next read completes.
// GSEL_B      out  1   bus select, active low
// GRDWR_B     out  1   1=read, 0=write. Valid whenever GSEL_B=0.
// gad_o       out  8   GAD output byte
// gad_oe_o    out  1   1=master drives GAD
// gad_i       in   8   GAD input byte, sampled on the rising edge
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: GSEL_B=1, GRDWR_B=1, gad_oe_o=0, gad_o=0, busy_o=0, ack_o=0, dat_o=0.
//   Reset mid-transaction aborts it. GSEL_B returns to 1 at the reset edge, no ack_o is issued,
//   and the next state is IDLE.
// - States: IDLE -> ADDR0 -> ADDR1 -> {write: WDATA x4 | read: TURN xRD_WAIT -> RDATA x4} -> GAP xIDLE_GAP -> IDLE.
// - IDLE: on req_i=1, latch we/adr/dat, set busy_o=1, go to ADDR0.
//   req_i while busy_o=1 is ignored. There is no queue.
// - ADDR0: GSEL_B=0, gad_oe_o=1, gad_o=adr[7:0], GRDWR_B=~we.
// - ADDR1: gad_o=adr[15:8].
// - WDATA: 4 beats, gad_o = dat[7:0], [15:8], [23:16], [31:24]. GSEL_B=0, GRDWR_B=0.
// - TURN: gad_oe_o=0, GSEL_B=0, GRDWR_B=1. Lasts RD_WAIT cycles; the slave drives GAD after this.
// - RDATA: 4 beats with gad_oe_o=0. Shift gad_i into an assembly register, LSB byte first.
//   The beat-k byte is taken at the rising edge that ends beat k.
// - GAP: GSEL_B=1, gad_oe_o=0. ack_o=1 in the first GAP cycle only.
//   On a read, dat_o updates in that same cycle. busy_o stays 1 until GAP ends.
// - Latency, req edge to ack_o: write 2+4+1 = 7 cycles; read 2+RD_WAIT+4+1 = 8 at the default.
// - No back-to-back issue: a new request can be accepted at the earliest in the IDLE cycle
//   after the last GAP cycle.
// - gad_oe_o never goes 1 in the cycle right after a cycle with gad_oe_o=0 inside a read.
//   This guarantees at least one turnaround cycle, because GAP >= 1 precedes the next ADDR0.
// - Beat counter: 2 bits, wraps 3->0 on exiting the data phase. Wait counter: 3 bits.
// - dat_i/adr_i/we_i changes after acceptance have no effect on the transaction in flight.
// TESTING
// 1) Write adr=0x0042, dat=0xDEADBEEF -> GAD bytes 42,00,EF,BE,AD,DE with GSEL_B=0 and GRDWR_B=0
//    for 6 cycles. ack_o in cycle 7. dat_o unchanged.
// 2) Read adr=0x0010; the slave model drives 78,56,34,12 after the turnaround ->
//    dat_o=0x12345678 with ack_o at cycle 8. gad_oe_o=0 from TURN through GAP.
// 3) RD_WAIT=3 build, same read -> ack_o at cycle 10. The master never drives GAD during TURN.
// 4) req_i pulsed again during WDATA beat 2 -> ignored. Exactly one ack_o. Bus bytes identical to test 1.
// 5) rst_i asserted during RDATA beat 1 -> next edge GSEL_B=1, busy_o=0, gad_oe_o=0, no ack_o.
//    A subsequent read completes normally.
// 6) Back-to-back: write then read, each req issued on the cycle busy_o falls -> GSEL_B high for
//    exactly IDLE_GAP+1 cycles between the two transactions. Both acks seen, read data correct.

Source files
------------

// File: rtl/glitcbus_master.sv
// GLITCBUS initiator: serialises one 32-bit register read or write into the
// byte-wide GSEL_B/GRDWR_B/GAD sequence. Every output comes straight from a
// flop. Each flop is loaded from a value decoded from the next state, so the
// bus pins change on the same edge as the state register.
module glitcbus_master #(
  parameter int RD_WAIT  = 1,
  parameter int IDLE_GAP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        GSEL_B,
  output logic        GRDWR_B,
  output logic [7:0]  gad_o,
  output logic        gad_oe_o,
  input  logic [7:0]  gad_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_WDATA, S_TURN, S_RDATA, S_GAP
  } state_t;

  localparam logic [2:0] TURN_LAST = 3'(RD_WAIT - 1);
  localparam logic [2:0] GAP_LAST  = 3'(IDLE_GAP - 1);

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  wait_q, wait_d;
  logic        we_q, we_d;
  logic [15:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] rdat_q, rdat_d;
  logic        gsel_b_q, gsel_b_d;
  logic        grdwr_b_q, grdwr_b_d;
  logic [7:0]  gad_q, gad_d;
  logic        gad_oe_q, gad_oe_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;

  // Sequencing: request capture, phase/beat/wait counting, read assembly.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    shift_d = shift_q;
    rdat_d  = rdat_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          adr_d   = adr_i;
          wdat_d  = dat_i;
          state_d = S_ADDR0;
        end
      end
      S_ADDR0: state_d = S_ADDR1;
      S_ADDR1: begin
        beat_d  = 2'd0;
        wait_d  = 3'd0;
        state_d = we_q ? S_WDATA : S_TURN;
      end
      S_WDATA: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          wait_d  = 3'd0;
          state_d = S_GAP;
        end
      end
      S_TURN: begin
        if (wait_q == TURN_LAST) begin
          beat_d  = 2'd0;
          state_d = S_RDATA;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_RDATA: begin
        // LSB byte arrives first, so shift new bytes in from the top
        shift_d = {gad_i, shift_q[31:8]};
        beat_d  = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          rdat_d  = {gad_i, shift_q[31:8]};
          wait_d  = 3'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (wait_q == GAP_LAST) state_d = S_IDLE;
        else                    wait_d  = wait_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin decode from the upcoming state so the output flops line up with it.
  always_comb begin
    gsel_b_d  = 1'b1;
    grdwr_b_d = 1'b1;
    gad_d     = 8'h00;
    gad_oe_d  = 1'b0;
    busy_d    = (state_d != S_IDLE);
    ack_d     = (state_d == S_GAP) && (state_q != S_GAP);
    case (state_d)
      S_ADDR0: begin
        gsel_b_d  = 1'b0;
        grdwr_b_d = ~we_d;
        gad_oe_d  = 1'b1;
        gad_d     = adr_d[7:0];
      end
      S_ADDR1: begin
        gsel_b_d  = 1'b0;
        grdwr_b_d = ~we_d;
        gad_oe_d  = 1'b1;
        gad_d     = adr_d[15:8];
      end
      S_WDATA: begin
        gsel_b_d  = 1'b0;
        grdwr_b_d = 1'b0;
        gad_oe_d  = 1'b1;
        gad_d     = wdat_d[{beat_d, 3'b000} +: 8];
      end
      S_TURN, S_RDATA: begin
        gsel_b_d  = 1'b0;
        grdwr_b_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      beat_q    <= 2'd0;
      wait_q    <= 3'd0;
      we_q      <= 1'b0;
      adr_q     <= 16'h0000;
      wdat_q    <= 32'h0;
      shift_q   <= 32'h0;
      rdat_q    <= 32'h0;
      gsel_b_q  <= 1'b1;
      grdwr_b_q <= 1'b1;
      gad_q     <= 8'h00;
      gad_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      shift_q   <= shift_d;
      rdat_q    <= rdat_d;
      gsel_b_q  <= gsel_b_d;
      grdwr_b_q <= grdwr_b_d;
      gad_q     <= gad_d;
      gad_oe_q  <= gad_oe_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  assign busy_o   = busy_q;
  assign ack_o    = ack_q;
  assign dat_o    = rdat_q;
  assign GSEL_B   = gsel_b_q;
  assign GRDWR_B  = grdwr_b_q;
  assign gad_o    = gad_q;
  assign gad_oe_o = gad_oe_q;

endmodule

// File: tb/tb_glitcbus_master.sv
// Bench for glitcbus_master: dut_a uses default timing, and dut_b uses
// RD_WAIT=3, IDLE_GAP=2. The expected bus picture per cycle comes from the
// phase lengths (2 address beats, 4 data beats, turnaround, gap).
module tb_glitcbus_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_a, req_b, we;
  logic [15:0] adr;
  logic [31:0] dat;
  logic [7:0]  gad_drv;

  logic        busy_a, ack_a, gsel_a, rdwr_a, oe_a;
  logic [7:0]  gad_a;
  logic [31:0] do_a;
  logic        busy_b, ack_b, gsel_b, rdwr_b, oe_b;
  logic [7:0]  gad_b;
  logic [31:0] do_b;

  glitcbus_master dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we), .adr_i(adr), .dat_i(dat),
    .busy_o(busy_a), .ack_o(ack_a), .dat_o(do_a), .GSEL_B(gsel_a), .GRDWR_B(rdwr_a),
    .gad_o(gad_a), .gad_oe_o(oe_a), .gad_i(gad_drv));

  glitcbus_master #(.RD_WAIT(3), .IDLE_GAP(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we), .adr_i(adr), .dat_i(dat),
    .busy_o(busy_b), .ack_o(ack_b), .dat_o(do_b), .GSEL_B(gsel_b), .GRDWR_B(rdwr_b),
    .gad_o(gad_b), .gad_oe_o(oe_b), .gad_i(gad_drv));

  // Observation mux selects whichever DUT the current transaction targets
  logic        cur;
  logic        o_busy, o_ack, o_gsel, o_rdwr, o_oe;
  logic [7:0]  o_gad;
  logic [31:0] o_dat;
  assign o_busy = cur ? busy_b : busy_a;
  assign o_ack  = cur ? ack_b  : ack_a;
  assign o_gsel = cur ? gsel_b : gsel_a;
  assign o_rdwr = cur ? rdwr_b : rdwr_a;
  assign o_oe   = cur ? oe_b   : oe_a;
  assign o_gad  = cur ? gad_b  : gad_a;
  assign o_dat  = cur ? do_b   : do_a;

  int checks = 0;
  int errors = 0;
  int acks_a = 0;
  int hi_cnt = 0;
  int last_hi = 0;
  logic [31:0] exp_dat [2];

  // dut_a ack count and length of the last GSEL_B-high run
  always @(negedge clk) begin
    if (!rst && ack_a) acks_a <= acks_a + 1;
    if (gsel_a) hi_cnt <= hi_cnt + 1;
    else begin
      if (hi_cnt != 0) last_hi <= hi_cnt;
      hi_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction; poke_c re-pulses req in that cycle, rst_c resets at end of that cycle
  task automatic txn(input bit sel, input bit w, input logic [15:0] a, input logic [31:0] d,
                     input int poke_c, input int rst_c, input logic [31:0] rdata);
    int rw, gp, lat, n;
    logic e_oe, in_bus;
    logic [7:0] e_gad;
    logic [12:0] ov, ev;
    rw  = sel ? 3 : 1;
    gp  = sel ? 2 : 1;
    lat = w ? 7 : 7 + rw;
    cur = sel;
    n = 0;
    while (o_busy && n < 50) begin @(negedge clk); n++; end
    if (o_busy) begin chk("idle_timeout", 64'(o_busy), 64'd0); return; end
    req_a = !sel; req_b = sel; we = w; adr = a; dat = d;
    for (int c = 1; c <= lat + gp; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_a = 1'b0; req_b = 1'b0;
        we = 1'($urandom); adr = 16'($urandom); dat = $urandom;
      end
      if (c == poke_c) begin
        req_a = !sel; req_b = sel; we = 1'($urandom); adr = 16'($urandom);
      end else if (c == poke_c + 1) begin
        req_a = 1'b0; req_b = 1'b0;
      end
      if (!w && c >= 3 + rw && c <= 6 + rw) gad_drv = rdata[8*(c-3-rw) +: 8];
      else gad_drv = 8'($urandom);
      in_bus = (c < lat);
      e_oe   = (c <= 2) || (w && c <= 6);
      e_gad  = (c == 1) ? a[7:0] : (c == 2) ? a[15:8] : d[8*((c-3)&3) +: 8];
      ev = {!in_bus, c < lat + gp, c == lat, e_oe, in_bus ? !w : 1'b0, e_oe ? e_gad : 8'h00};
      ov = {o_gsel, o_busy, o_ack, o_oe, in_bus ? o_rdwr : 1'b0, e_oe ? o_gad : 8'h00};
      chk($sformatf("bus dut%0d we%0d c%0d", sel, w, c), 64'(ov), 64'(ev));
      chk($sformatf("dat_o dut%0d c%0d", sel, c), 64'(o_dat),
          64'((c >= lat && !w) ? rdata : exp_dat[sel]));
      if (c == rst_c) begin
        rst = 1'b1;
        @(negedge clk);
        chk("reset_abort", {27'd0, o_gsel, o_rdwr, o_oe, o_gad, o_busy, o_ack, o_dat},
            {27'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0});
        rst = 1'b0;
        exp_dat[0] = 32'h0; exp_dat[1] = 32'h0;
        repeat (3) begin
          @(negedge clk);
          chk("post_reset_idle", 64'({o_busy, o_ack, o_gsel, o_oe}), 64'(4'b0010));
        end
        return;
      end
    end
    if (!w) exp_dat[sel] = rdata;
  endtask

  initial begin
    int a0;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; adr = '0; dat = '0; gad_drv = '0;
    cur = 1'b0; exp_dat[0] = 32'h0; exp_dat[1] = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_a", {19'd0, gsel_a, rdwr_a, oe_a, gad_a, busy_a, ack_a, do_a},
        {19'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0});
    chk("reset_b", {19'd0, gsel_b, rdwr_b, oe_b, gad_b, busy_b, ack_b, do_b},
        {19'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    // directed: write, read, long-turnaround read
    txn(0, 1, 16'h0042, 32'hDEADBEEF, 0, 0, 32'h0);
    txn(0, 0, 16'h0010, 32'h0, 0, 0, 32'h12345678);
    txn(1, 0, 16'h0010, 32'h0, 0, 0, 32'h12345678);

    // request during WDATA beat 2 is dropped
    a0 = acks_a;
    txn(0, 1, 16'h0042, 32'hDEADBEEF, 4, 0, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("no_queued_txn", 64'({busy_a, gsel_a}), 64'(2'b01));
    end
    chk("single_ack", 64'(acks_a - a0), 64'd1);

    // reset in RDATA beat 1, then a clean read
    txn(0, 0, 16'h0020, 32'h0, 0, 4, 32'hA5A5A5A5);
    txn(0, 0, 16'h0050, 32'h0, 0, 0, 32'hCAFEF00D);

    // back-to-back write then read
    a0 = acks_a;
    txn(0, 1, 16'h0040, 32'h01020304, 0, 0, 32'h0);
    txn(0, 0, 16'h0000, 32'h0, 0, 0, 32'h89ABCDEF);
    chk("gap_high_cycles", 64'(last_hi), 64'd2);
    chk("b2b_acks", 64'(acks_a - a0), 64'd2);

    // randomized traffic on both configurations
    for (int i = 0; i < 24; i++)
      txn(1'($urandom), 1'($urandom), 16'($urandom), $urandom, 0, 0, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end
endmodule
